// File: rtl/rv32_pkg.sv
// rv32_pkg: shared writeback select codes, load funct3 encodings and writeback FSM states
package rv32_pkg;
  typedef enum logic [1:0] {SEL_ALU = 2'd0, SEL_LOAD = 2'd1, SEL_LINK = 2'd2, SEL_NONE = 2'd3} wb_sel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_WAIT = 2'd1, COMMIT = 2'd2} wb_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half lane, extends it, and flags misaligned or illegal loads
module load_extend
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select and extension; 011/110/111 are not RV32I loads
  always_comb begin
    b          = rdata[8*offset +: 8];
    h          = rdata[16*offset[1] +: 16];
    data       = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                 funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                 funct3 == F3_LW  ? rdata :
                 funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                 funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : '0;
    illegal    = funct3 == 3'b011 || funct3[2:1] == 2'b11;
    misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && offset[0]) || (funct3 == F3_LW && offset != 2'b00);
  end
endmodule

// File: rtl/load_writeback.sv
// load_writeback: RV32I writeback stage; runs load handshakes and pulses the register-file write port
module load_writeback
  import rv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        wb_funct3,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc_plus4,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   reg_write,
  output logic [REG_AW-1:0] rd,
  output logic              write,
  output logic              load_fault,
  output logic              stall
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  wb_state_t         state;
  wb_sel_t           sel;
  logic [CW-1:0]     cnt;
  logic [REG_AW-1:0] ld_rd;
  logic [2:0]        ld_f3;
  logic [1:0]        ld_off;
  logic [XLEN-1:0]   ext_data;
  logic              misaligned, illegal;
  logic              in_wait;
  assign in_wait  = state == LOAD_WAIT;
  assign wb_ready = !in_wait;
  assign stall    = wb_valid && in_wait;
  assign sel      = wb_sel_t'(wb_sel);
  // one extender serves both the acceptance-time fault check and the returned-data extension
  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3     (in_wait ? ld_f3 : wb_funct3),
    .offset     (in_wait ? ld_off : alu_result[1:0]),
    .rdata      (mem_rdata),
    .data       (ext_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );
  // writeback FSM: accept, wait for load ack or timeout, pulse write/fault for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_rd      <= '0;
      ld_f3      <= '0;
      ld_off     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      reg_write  <= '0;
      rd         <= '0;
      write      <= 1'b0;
      load_fault <= 1'b0;
    end else begin
      write      <= 1'b0;
      load_fault <= 1'b0;
      if (in_wait) begin
        if (mem_ack) begin
          state   <= COMMIT;
          mem_req <= 1'b0;
          if (ld_rd != '0) begin
            write     <= 1'b1;
            rd        <= ld_rd;
            reg_write <= ext_data;
          end
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          state      <= IDLE;
          mem_req    <= 1'b0;
          load_fault <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (wb_valid) begin
        if (sel == SEL_LOAD) begin
          if (misaligned || illegal) begin
            state      <= IDLE;
            load_fault <= 1'b1;
          end else begin
            state    <= LOAD_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= {alu_result[XLEN-1:2], 2'b00};
            cnt      <= '0;
            ld_rd    <= wb_rd;
            ld_f3    <= wb_funct3;
            ld_off   <= alu_result[1:0];
          end
        end else begin
          state <= COMMIT;
          if (sel != SEL_NONE && wb_rd != '0) begin
            write     <= 1'b1;
            rd        <= wb_rd;
            reg_write <= sel == SEL_LINK ? pc_plus4 : alu_result;
          end
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_load_writeback.sv
// tb_load_writeback: directed checks of ALU/LINK commit, load extension, load faults, timeout and async reset
module tb_load_writeback;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [1:0]  wb_sel = '0;
  logic [2:0]  wb_funct3 = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_plus4 = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] reg_write;
  logic [4:0]  rd;
  logic        write;
  logic        load_fault;
  logic        stall;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  load_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_sel     (wb_sel),
    .wb_funct3  (wb_funct3),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .reg_write  (reg_write),
    .rd         (rd),
    .write      (write),
    .load_fault (load_fault),
    .stall      (stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] s, input logic [4:0] r, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] pc);
    wb_valid = 1'b1; wb_sel = s; wb_rd = r; wb_funct3 = f3; alu_result = a; pc_plus4 = pc;
  endtask

  initial begin
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ready", wb_ready, 1);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("idle_ready", wb_ready, 1);
    chk("idle_write", write, 0);
    chk("idle_fault", load_fault, 0);
    chk("idle_stall", stall, 0);
    chk("idle_rd", rd, 0);
    chk("idle_reg_write", reg_write, 0);
    // ALU write, one-cycle pulse
    issue(2'd0, 5'd5, 3'd0, 32'hDEADBEEF, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("alu_write", write, 1);
    chk("alu_rd", rd, 5);
    chk("alu_data", reg_write, 32'hDEADBEEF);
    step();
    chk("alu_write_off", write, 0);
    chk("alu_data_hold", reg_write, 32'hDEADBEEF);
    // LB at 0x1003, ack after three wait cycles, younger NONE held off meanwhile
    issue(2'd1, 5'd7, 3'b000, 32'h00001003, 32'h0);
    step();
    issue(2'd3, 5'd9, 3'd0, 32'h0, 32'h0);
    chk("lb_req", mem_req, 1);
    chk("lb_addr", mem_addr, 32'h00001000);
    chk("lb_ready", wb_ready, 0);
    chk("lb_stall", stall, 1);
    chk("lb_no_write", write, 0);
    repeat (3) step();
    chk("lb_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h80FF0000;
    step();
    mem_ack = 1'b0; wb_valid = 1'b0;
    chk("lb_write", write, 1);
    chk("lb_rd", rd, 7);
    chk("lb_data", reg_write, 32'hFFFFFF80);
    chk("lb_req_drop", mem_req, 0);
    chk("lb_ready_back", wb_ready, 1);
    step();
    chk("none_write", write, 0);
    // LHU then LH back-to-back from COMMIT
    issue(2'd1, 5'd3, 3'b101, 32'h00002002, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("lhu_addr", mem_addr, 32'h00002000);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF1234;
    step();
    mem_ack = 1'b0;
    chk("lhu_data", reg_write, 32'h0000BEEF);
    chk("lhu_write", write, 1);
    issue(2'd1, 5'd4, 3'b001, 32'h00002002, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("lh_req", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lh_data", reg_write, 32'hFFFFBEEF);
    chk("lh_rd", rd, 4);
    step();
    // misaligned LW and illegal funct3
    issue(2'd1, 5'd10, 3'b010, 32'h00001002, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("lw_mis_fault", load_fault, 1);
    chk("lw_mis_req", mem_req, 0);
    chk("lw_mis_write", write, 0);
    chk("lw_mis_ready", wb_ready, 1);
    step();
    chk("lw_mis_pulse", load_fault, 0);
    issue(2'd1, 5'd10, 3'b011, 32'h00001000, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("ill_fault", load_fault, 1);
    chk("ill_req", mem_req, 0);
    chk("ill_write", write, 0);
    step();
    chk("ill_pulse", load_fault, 0);
    // timeout: 16 wait cycles without ack, fault on the 17th
    issue(2'd1, 5'd6, 3'b010, 32'h00003000, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("to_req_w1", mem_req, 1);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk("to_req_wait", mem_req, 1);
      chk("to_no_fault", load_fault, 0);
    end
    step();
    chk("to_fault", load_fault, 1);
    chk("to_req_drop", mem_req, 0);
    chk("to_write", write, 0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("late_ack_write", write, 0);
    chk("late_ack_fault", load_fault, 0);
    chk("late_ack_data", reg_write, 32'hFFFFBEEF);
    // LINK rd=8 then LINK rd=0 back-to-back
    issue(2'd2, 5'd8, 3'd0, 32'h0, 32'h00000100);
    step();
    issue(2'd2, 5'd0, 3'd0, 32'h0, 32'h00000044);
    chk("link_write", write, 1);
    chk("link_data", reg_write, 32'h00000100);
    step();
    wb_valid = 1'b0;
    chk("link_r0_write", write, 0);
    chk("link_r0_rd_hold", rd, 8);
    chk("link_r0_data_hold", reg_write, 32'h00000100);
    step();
    // async reset during LOAD_WAIT
    issue(2'd1, 5'd2, 3'b010, 32'h00004000, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("rst_load_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_ready", wb_ready, 1);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_ready", wb_ready, 1);
    chk("post_rst_req", mem_req, 0);
    issue(2'd0, 5'd1, 3'd0, 32'h00000055, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("post_rst_alu", reg_write, 32'h00000055);
    chk("post_rst_write", write, 1);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
